// File: rtl/conv.sv
// conv: sequential 3x3 valid-mode convolution engine.
// One output pixel is computed per CALC cycle, then held in WAIT until the
// downstream writer acknowledges it with save_done. ReLU is applied when the
// latched layer is 0 (conv1) and bypassed when it is 1 (conv2).
module conv #(
  parameter int K_H        = 3,
  parameter int K_W        = 3,
  parameter int MAX_H      = 16,
  parameter int MAX_W      = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         trigger,
  input  logic                         save_done,
  input  logic [4:0]                   in_w,
  input  logic [4:0]                   in_h,
  input  logic [3:0]                   chan,
  input  logic                         layer,
  input  logic [DATA_WIDTH-1:0]        in_img [MAX_H][MAX_W],
  input  logic signed [DATA_WIDTH-1:0] w_conv [K_H][K_W],
  output logic                         valid,
  output logic                         done,
  output logic signed [23:0]           out_pixel,
  output logic [7:0]                   addr
);

  // Row/column index widths wide enough to address any image position.
  localparam int RW    = $clog2(MAX_H);
  localparam int CW    = $clog2(MAX_W);
  localparam int ACC_W = 24;
  localparam int NTAP  = K_H * K_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state;
  logic              trig_prev;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [RW-1:0]     last_row;
  logic [CW-1:0]     last_col;
  logic [7:0]        idx;
  logic              layer_q;
  logic [3:0]        chan_q;

  logic              start;
  logic              degenerate;
  logic              is_last;
  logic signed [ACC_W-1:0] prod [NTAP];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] result;

  assign start      = trigger & ~trig_prev;
  assign degenerate = (in_h < 5'd3) || (in_w < 5'd3);
  assign is_last    = (row == last_row) && (col == last_col);

  // One multiplier per kernel tap; the pixel is zero-extended so it is
  // treated as unsigned, the weight is sign-extended.
  for (genvar gi = 0; gi < NTAP; gi++) begin : g_tap
    localparam int TI = gi / K_W;
    localparam int TJ = gi % K_W;
    logic [RW-1:0]           r_idx;
    logic [CW-1:0]           c_idx;
    logic signed [ACC_W-1:0] pix_ext;
    logic signed [ACC_W-1:0] wt_ext;
    assign r_idx    = row + RW'(TI);
    assign c_idx    = col + CW'(TJ);
    assign pix_ext  = ACC_W'($signed({1'b0, in_img[r_idx][c_idx]}));
    assign wt_ext   = ACC_W'(w_conv[TI][TJ]);
    assign prod[gi] = pix_ext * wt_ext;
  end

  // Sum all tap products for the current window.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAP; k++) begin
      acc = acc + prod[k];
    end
  end

  // ReLU clips negative sums to zero for conv1 only.
  assign result = (!layer_q && acc[ACC_W-1]) ? '0 : acc;

  // Control FSM with registered outputs; trig_prev tracks trigger every cycle
  // so a level held high across a frame cannot start a second one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      trig_prev <= 1'b0;
      row       <= '0;
      col       <= '0;
      last_row  <= '0;
      last_col  <= '0;
      idx       <= '0;
      layer_q   <= 1'b0;
      chan_q    <= '0;
      valid     <= 1'b0;
      done      <= 1'b0;
      out_pixel <= '0;
      addr      <= '0;
    end else begin
      trig_prev <= trigger;
      case (state)
        IDLE: begin
          valid <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            layer_q  <= layer;
            chan_q   <= chan;
            last_row <= RW'(in_h - 5'd3);
            last_col <= CW'(in_w - 5'd3);
            row      <= '0;
            col      <= '0;
            idx      <= '0;
            if (degenerate) begin
              // No valid window: signal completion for one cycle only.
              done      <= 1'b1;
              addr      <= '0;
              out_pixel <= '0;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          out_pixel <= result;
          addr      <= idx;
          valid     <= 1'b1;
          done      <= is_last;
          state     <= WAIT;
        end
        WAIT: begin
          if (save_done) begin
            valid <= 1'b0;
            done  <= 1'b0;
            if (is_last) begin
              state <= IDLE;
            end else begin
              idx <= idx + 8'd1;
              if (col == last_col) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv.sv
// tb_conv: randomized self-checking bench for conv against a plain-arithmetic
// reference convolution.
module tb_conv;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              trigger = 1'b0;
  logic              save_done = 1'b0;
  logic [4:0]        in_w = 5'd15;
  logic [4:0]        in_h = 5'd16;
  logic [3:0]        chan = 4'd0;
  logic              layer = 1'b0;
  logic [7:0]        img [16][15];
  logic signed [7:0] wk [3][3];
  logic              valid;
  logic              done;
  logic signed [23:0] out_pixel;
  logic [7:0]        addr;

  int errors = 0;
  int checks = 0;
  int last_pix = 0;

  always #5 clk = ~clk;

  conv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trigger   (trigger),
    .save_done (save_done),
    .in_w      (in_w),
    .in_h      (in_h),
    .chan      (chan),
    .layer     (layer),
    .in_img    (img),
    .w_conv    (wk),
    .valid     (valid),
    .done      (done),
    .out_pixel (out_pixel),
    .addr      (addr)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: direct 3x3 dot product over the window, then optional ReLU.
  function automatic int ref_pix(input int r, input int c, input logic lay);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(img[r+i][c+j]) * int'(wk[i][j]);
    if (!lay && s < 0) s = 0;
    return s;
  endfunction

  task automatic fill_random_img();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 15; c++)
        img[r][c] = 8'($urandom);
  endtask

  task automatic fill_const(input logic [7:0] p, input logic signed [7:0] w);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 15; c++)
        img[r][c] = p;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        wk[i][j] = w;
  endtask

  // Wait for result k of n, check it, hold for 'hold' cycles, then acknowledge.
  task automatic consume(input int k, input int n, input int hold);
    int cnt;
    int ow;
    cnt = 0;
    ow  = int'(in_w) - 2;
    while (!valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("latency", cnt, 1);
    check("valid", int'(valid), 1);
    check("addr", int'(addr), k);
    check("pixel", int'(out_pixel), ref_pix(k / ow, k % ow, layer));
    check("done", int'(done), int'(k == n - 1));
    last_pix = int'(out_pixel);
    repeat (hold) tick();
    save_done = 1'b1;
    tick();
    save_done = 1'b0;
    check("ack_valid", int'(valid), 0);
    check("ack_done", int'(done), 0);
  endtask

  task automatic run_frame(input int h, input int w, input logic lay, input int hold);
    int n;
    in_h    = 5'(h);
    in_w    = 5'(w);
    layer   = lay;
    chan    = 4'($urandom);
    n       = (h - 2) * (w - 2);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int k = 0; k < n; k++) consume(k, n, hold);
    tick();
    check("idle_valid", int'(valid), 0);
    $display("frame h=%0d w=%0d layer=%0d results=%0d last=%0d", h, w, lay, n, last_pix);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit stable;

    fill_random_img();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        wk[i][j] = 8'((i - 1) + (j - 1));

    // Reset state
    tick();
    tick();
    check("rst_valid", int'(valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_pixel", int'(out_pixel), 0);
    rst_n = 1'b1;
    tick();

    // Gradient kernel, both layers
    run_frame(16, 15, 1'b0, 3);
    run_frame(16, 15, 1'b1, 3);

    // Random kernels and sizes
    for (int t = 0; t < 4; t++) begin
      fill_random_img();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          wk[i][j] = 8'($urandom);
      run_frame($urandom_range(3, 16), $urandom_range(3, 15), 1'($urandom), $urandom_range(0, 3));
    end

    // Handshake: save_done in IDLE and in CALC ignored, long hold, trigger in WAIT ignored
    in_h  = 5'd4;
    in_w  = 5'd4;
    layer = 1'b1;
    save_done = 1'b1;
    repeat (3) tick();
    check("sd_idle_valid", int'(valid), 0);
    save_done = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    save_done = 1'b1;
    tick();
    save_done = 1'b0;
    check("hs_valid", int'(valid), 1);
    check("hs_addr", int'(addr), 0);
    p0 = ref_pix(0, 0, 1'b1);
    check("hs_pixel", int'(out_pixel), p0);
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c == 10) trigger = 1'b1;
      if (c == 12) trigger = 1'b0;
      tick();
      if (valid !== 1'b1 || addr !== 8'd0 || int'(out_pixel) != p0) stable = 1'b0;
    end
    check("hs_stable", int'(stable), 1);
    save_done = 1'b1;
    tick();
    save_done = 1'b0;
    for (int k = 1; k < 4; k++) consume(k, 4, 1);
    $display("frame handshake 4x4 results=4");

    // Extreme values
    fill_const(8'd255, 8'sd127);
    run_frame(16, 15, 1'b0, 0);
    check("sat_pos", last_pix, 291465);
    fill_const(8'd255, -8'sd128);
    run_frame(16, 15, 1'b1, 0);
    check("sat_neg", last_pix, -293760);
    run_frame(16, 15, 1'b0, 0);
    check("sat_relu", last_pix, 0);

    // Minimum size, then a degenerate request
    fill_const(8'd255, 8'sd127);
    run_frame(3, 3, 1'b0, 0);
    run_frame(4, 5, 1'b0, 0);
    in_w = 5'd2;
    in_h = 5'd16;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("deg_done", int'(done), 1);
    check("deg_valid", int'(valid), 0);
    check("deg_addr", int'(addr), 0);
    check("deg_pixel", int'(out_pixel), 0);
    tick();
    check("deg_done_clr", int'(done), 0);
    $display("frame degenerate w=2 done pulse");

    // Reset mid-frame, then a fresh frame starts at addr 0
    fill_random_img();
    in_h  = 5'd16;
    in_w  = 5'd15;
    layer = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int k = 0; k < 5; k++) consume(k, 182, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(valid), 0);
    check("arst_done", int'(done), 0);
    check("arst_addr", int'(addr), 0);
    check("arst_pixel", int'(out_pixel), 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("arst_no_resume", int'(valid), 0);
    $display("frame aborted by reset after 5 results");
    run_frame(16, 15, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
